mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
// - Memory-side responder for the accelerator's block-memory interface: serves burst reads on the
//   inputMem* channels and absorbs burst writes on the outputMem* channels.
// - Backed by an on-chip 512-bit-wide RAM. Instantiated opposite the accelerator top in the
//   simulation harness and the FPGA self-test shell. Also tracks write completions and protocol errors.
// PARAMETERS
// - DEPTH_LOG2   10   RAM depth = 2**DEPTH_LOG2 blocks of 64 bytes each
// - CNT_BITS     32   width of the completed-write-burst counter
// PORTS
// - clock                input   1    single clock, all logic on posedge
// - reset                input   1    synchronous, active-high
// - inputMemAddr         input   64   read burst byte address (block-aligned; bits[5:0] ignored)
// - inputMemAddrValid    input   1    read request valid
// - inputMemAddrLen      input   8    read burst length minus one (1..256 beats)
// - inputMemAddrReady    output  1    read request accepted when valid&ready
// - inputMemBlock        output  512  read data beat
// - inputMemBlockValid   output  1    read data valid
// - inputMemBlockReady   input   1    read data consumed when valid&ready
// - outputMemAddr        input   64   write burst byte address (block-aligned)
// - outputMemAddrValid   input   1    write request valid
// - outputMemAddrLen     input   8    write burst length minus one
// - outputMemAddrId      input   16   write burst tag
// - outputMemAddrReady   output  1    write request accepted when valid&ready
// - outputMemBlock       input   512  write data beat
// - outputMemBlockValid  input   1    write data valid
// - outputMemBlockLast   input   1    final beat of the write burst
// - outputMemBlockReady  output  1    write beat accepted when valid&ready
// - finished             input   1    initiator done flag
// - writeBurstsDone      output  CNT_BITS  number of completed write bursts
// - lastWriteId          output  16   tag of the most recently completed write burst
// - protoError           output  1    sticky: write beat count != len+1
// - finishedSeen         output  1    sticky copy of finished
// BEHAVIOUR
// - Reset: all FSMs to IDLE; every output 0 except inputMemAddrReady=1 and outputMemAddrReady=1
//   (both IDLE states). RAM contents are not cleared.
// - Index: word = addr[6 +: DEPTH_LOG2]. Upper address bits are dropped. The burst index increments
//   once per beat and wraps modulo 2**DEPTH_LOG2.
// - Read FSM R_IDLE -> R_FETCH -> R_SEND:
//   - R_IDLE: ready=1. On accept, latch index and remaining=len, then go to R_FETCH.
//   - R_FETCH: issue the RAM read for the current index. Next state R_SEND; inputMemBlockValid rises
//     the next cycle, so first data is 2 cycles after address accept.
//   - R_SEND: valid=1, and data is held stable while ready=0.
//   - On a handshake with remaining>0: decrement, issue the next RAM read in the same cycle, and stay in
//     R_SEND. Sustained 1 beat/cycle with no bubbles.
//   - On a handshake with remaining==0: go to R_IDLE. inputMemAddrReady returns the next cycle, giving a
//     1-cycle gap between bursts.
// - Write FSM W_IDLE -> W_DATA:
//   - W_IDLE: outputMemAddrReady=1, outputMemBlockReady=0. On accept, latch index, id and
//     expected=len, then go to W_DATA.
//   - W_DATA: outputMemBlockReady=1. Each accepted beat writes the RAM at index, increments index and
//     increments the beat count.
//   - The burst ends on an accepted beat with Last=1. writeBurstsDone is incremented (wraps at
//     2**CNT_BITS), lastWriteId is updated, and the FSM returns to W_IDLE.
//   - If a beat arrives with Last=1 and count!=expected, or count reaches expected and Last=0: set
//     protoError. The burst still runs until Last is seen, and the index keeps wrapping.
// - Read and write FSMs run independently and concurrently.
// - Same-cycle read and write to the same word: the read returns old data (read-first). The new data is
//   visible to reads issued on the following cycle or later.
// - finishedSeen is set on the cycle after finished=1, and only reset clears it.
// - Reset mid-burst aborts both bursts immediately. A partially written burst leaves the written beats in
//   RAM. No counter increments for the aborted burst.
// STRUCTURE
// - mem_responder_pkg:
//   - BLOCK_BITS=512, BLOCK_OFFSET_BITS=6
//   - typedef enum rd_state_t {R_IDLE, R_FETCH, R_SEND}
//   - typedef enum wr_state_t {W_IDLE, W_DATA}
// - Sub-module block_ram: 1R1W, synchronous read, read-first, parameters WIDTH=512 and DEPTH_LOG2.
// - Read FSM, write FSM and status registers live in mem_responder.
// TESTING
// - Write then read: write addr 0x40, len 3, data 1..4 with Last on beat 4.
//   - Then read addr 0x40, len 3 with ready held high.
//   - Required: 4 beats returning 1..4 on consecutive cycles, first beat 2 cycles after address accept.
//   - Required: writeBurstsDone=1, lastWriteId matches.
// - Read backpressure: read len 7 with ready toggling 1/0.
//   - Required: data held stable while ready=0, no beat dropped or duplicated, 8 beats in order.
// - Wrap: DEPTH_LOG2=4, write addr 15*64, len 1, data A,B.
//   - Required: A lands in word 15, B in word 0. Reading addr 0 returns B.
// - Collision: read and write of word 5 (old X, new Y) in the same cycle.
//   - Required: the read returns X, and a read issued one cycle later returns Y.
// - Protocol error: write len 3 with Last on beat 2.
//   - Required: protoError=1, writeBurstsDone increments, FSM back in W_IDLE.
//   - Required: a following legal burst completes normally.
// - Reset mid-burst: assert reset during beat 3 of a len-7 read and a len-7 write.
//   - Required: next cycle both address readies are 1, valid=0, counters 0.
//   - Required: earlier written beats are still readable.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared widths and FSM state types for the memory responder.
//   BLOCK_BITS / BLOCK_OFFSET_BITS : one RAM word is one 64-byte block
//   ADDR_BITS / LEN_BITS / ID_BITS : request channel field widths
package mem_responder_pkg;
    localparam int BLOCK_BITS        = 512;
    localparam int BLOCK_OFFSET_BITS = 6;
    localparam int ADDR_BITS         = 64;
    localparam int LEN_BITS          = 8;
    localparam int ID_BITS           = 16;

    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_SEND} rd_state_t;
    typedef enum logic       {W_IDLE, W_DATA}          wr_state_t;
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: block-memory bus between the accelerator (master) and the
// memory responder (slave).
//   inputMem*  : read burst address channel and read data channel
//   outputMem* : write burst address channel and write data channel
interface mem_responder_if;
    import mem_responder_pkg::*;

    logic [ADDR_BITS-1:0]  inputMemAddr;
    logic                  inputMemAddrValid;
    logic [LEN_BITS-1:0]   inputMemAddrLen;
    logic                  inputMemAddrReady;
    logic [BLOCK_BITS-1:0] inputMemBlock;
    logic                  inputMemBlockValid;
    logic                  inputMemBlockReady;

    logic [ADDR_BITS-1:0]  outputMemAddr;
    logic                  outputMemAddrValid;
    logic [LEN_BITS-1:0]   outputMemAddrLen;
    logic [ID_BITS-1:0]    outputMemAddrId;
    logic                  outputMemAddrReady;
    logic [BLOCK_BITS-1:0] outputMemBlock;
    logic                  outputMemBlockValid;
    logic                  outputMemBlockLast;
    logic                  outputMemBlockReady;

    modport master (
        output inputMemAddr, inputMemAddrValid, inputMemAddrLen,
        input  inputMemAddrReady,
        input  inputMemBlock, inputMemBlockValid,
        output inputMemBlockReady,
        output outputMemAddr, outputMemAddrValid, outputMemAddrLen, outputMemAddrId,
        input  outputMemAddrReady,
        output outputMemBlock, outputMemBlockValid, outputMemBlockLast,
        input  outputMemBlockReady
    );

    modport slave (
        input  inputMemAddr, inputMemAddrValid, inputMemAddrLen,
        output inputMemAddrReady,
        output inputMemBlock, inputMemBlockValid,
        input  inputMemBlockReady,
        input  outputMemAddr, outputMemAddrValid, outputMemAddrLen, outputMemAddrId,
        output outputMemAddrReady,
        input  outputMemBlock, outputMemBlockValid, outputMemBlockLast,
        output outputMemBlockReady
    );
endinterface

// File: rtl/mem_responder_block_ram.sv
// block_ram: 1R1W RAM with a registered (synchronous) read port.
//   clock, reset      : reset clears only the read data register, never the array
//   rdEn/rdAddr/rdData: read issued on rdEn, data valid the following cycle, held otherwise
//   wrEn/wrAddr/wrData: write port
// A read and write of the same word in one cycle returns the old contents.
module block_ram #(
    parameter int WIDTH      = 512,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rdEn,
    input  logic [DEPTH_LOG2-1:0] rdAddr,
    output logic [WIDTH-1:0]      rdData,
    input  logic                  wrEn,
    input  logic [DEPTH_LOG2-1:0] wrAddr,
    input  logic [WIDTH-1:0]      wrData
);
    logic [WIDTH-1:0] ram [2**DEPTH_LOG2];

    always_ff @(posedge clock) begin
        if (wrEn) ram[wrAddr] <= wrData;
    end

    always_ff @(posedge clock) begin
        if (reset)     rdData <= '0;
        else if (rdEn) rdData <= ram[rdAddr];
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder serving burst reads and absorbing burst
// writes against an on-chip block RAM, with write-completion and protocol status.
//   clock, reset    : single clock, synchronous active-high reset
//   mem             : slave side of the block-memory bus
//   finished        : initiator done flag
//   writeBurstsDone : completed write bursts (wraps)
//   lastWriteId     : tag of the most recently completed write burst
//   protoError      : sticky, a write burst's beat count disagreed with its length
//   finishedSeen    : sticky copy of finished
//
// state   | meaning
// R_IDLE  | read address ready, no burst in flight
// R_FETCH | RAM read of the first beat issued
// R_SEND  | beat presented; each handshake prefetches the next beat
// W_IDLE  | write address ready
// W_DATA  | accepting write beats until Last
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int CNT_BITS   = 32
) (
    input  logic                clock,
    input  logic                reset,
    mem_responder_if.slave      mem,
    input  logic                finished,
    output logic [CNT_BITS-1:0] writeBurstsDone,
    output logic [ID_BITS-1:0]  lastWriteId,
    output logic                protoError,
    output logic                finishedSeen
);
    localparam logic [DEPTH_LOG2-1:0] IDX_ONE = 1;
    localparam logic [CNT_BITS-1:0]   CNT_ONE = 1;
    localparam logic [LEN_BITS-1:0]   LEN_ONE = 1;

    rd_state_t             rdState;
    logic [DEPTH_LOG2-1:0] rdIndex;
    logic [LEN_BITS-1:0]   rdRemaining;
    logic                  rdBeatTaken;
    logic                  ramRdEn;

    wr_state_t             wrState;
    logic [DEPTH_LOG2-1:0] wrIndex;
    logic [ID_BITS-1:0]    wrId;
    logic [LEN_BITS-1:0]   wrExpected;
    logic [LEN_BITS-1:0]   wrCount;
    logic                  wrBeatTaken;

    // Block offset and address bits above the RAM depth are dropped.
    logic unusedAddrBits;
    assign unusedAddrBits = ^{mem.inputMemAddr[ADDR_BITS-1:BLOCK_OFFSET_BITS+DEPTH_LOG2],
                              mem.inputMemAddr[BLOCK_OFFSET_BITS-1:0],
                              mem.outputMemAddr[ADDR_BITS-1:BLOCK_OFFSET_BITS+DEPTH_LOG2],
                              mem.outputMemAddr[BLOCK_OFFSET_BITS-1:0]};

    // rdIndex always points at the next word to fetch, so a handshake can
    // prefetch the following beat in the same cycle without a bubble.
    assign rdBeatTaken = (rdState == R_SEND) && mem.inputMemBlockValid && mem.inputMemBlockReady;
    assign ramRdEn     = !reset && ((rdState == R_FETCH) || (rdBeatTaken && rdRemaining != '0));
    assign wrBeatTaken = !reset && (wrState == W_DATA) && mem.outputMemBlockValid
                         && mem.outputMemBlockReady;

    block_ram #(.WIDTH(BLOCK_BITS), .DEPTH_LOG2(DEPTH_LOG2)) blockRam (
        .clock  (clock),
        .reset  (reset),
        .rdEn   (ramRdEn),
        .rdAddr (rdIndex),
        .rdData (mem.inputMemBlock),
        .wrEn   (wrBeatTaken),
        .wrAddr (wrIndex),
        .wrData (mem.outputMemBlock)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            rdState                <= R_IDLE;
            rdIndex                <= '0;
            rdRemaining            <= '0;
            mem.inputMemAddrReady  <= 1'b1;
            mem.inputMemBlockValid <= 1'b0;
        end else begin
            case (rdState)
                R_IDLE: begin
                    if (mem.inputMemAddrValid) begin
                        rdIndex               <= mem.inputMemAddr[BLOCK_OFFSET_BITS +: DEPTH_LOG2];
                        rdRemaining           <= mem.inputMemAddrLen;
                        mem.inputMemAddrReady <= 1'b0;
                        rdState               <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    rdIndex                <= rdIndex + IDX_ONE;
                    mem.inputMemBlockValid <= 1'b1;
                    rdState                <= R_SEND;
                end
                R_SEND: begin
                    if (rdBeatTaken) begin
                        if (rdRemaining != '0) begin
                            rdRemaining <= rdRemaining - LEN_ONE;
                            rdIndex     <= rdIndex + IDX_ONE;
                        end else begin
                            mem.inputMemBlockValid <= 1'b0;
                            mem.inputMemAddrReady  <= 1'b1;
                            rdState                <= R_IDLE;
                        end
                    end
                end
                default: begin
                    mem.inputMemBlockValid <= 1'b0;
                    mem.inputMemAddrReady  <= 1'b1;
                    rdState                <= R_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wrState                 <= W_IDLE;
            wrIndex                 <= '0;
            wrId                    <= '0;
            wrExpected              <= '0;
            wrCount                 <= '0;
            mem.outputMemAddrReady  <= 1'b1;
            mem.outputMemBlockReady <= 1'b0;
            writeBurstsDone         <= '0;
            lastWriteId             <= '0;
            protoError              <= 1'b0;
        end else begin
            case (wrState)
                W_IDLE: begin
                    if (mem.outputMemAddrValid) begin
                        wrIndex                 <= mem.outputMemAddr[BLOCK_OFFSET_BITS +: DEPTH_LOG2];
                        wrId                    <= mem.outputMemAddrId;
                        wrExpected              <= mem.outputMemAddrLen;
                        wrCount                 <= '0;
                        mem.outputMemAddrReady  <= 1'b0;
                        mem.outputMemBlockReady <= 1'b1;
                        wrState                 <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wrBeatTaken) begin
                        wrIndex <= wrIndex + IDX_ONE;
                        wrCount <= wrCount + LEN_ONE;
                        // wrCount is the zero-based index of the current beat.
                        if (mem.outputMemBlockLast) begin
                            if (wrCount != wrExpected) protoError <= 1'b1;
                            writeBurstsDone         <= writeBurstsDone + CNT_ONE;
                            lastWriteId             <= wrId;
                            mem.outputMemAddrReady  <= 1'b1;
                            mem.outputMemBlockReady <= 1'b0;
                            wrState                 <= W_IDLE;
                        end else if (wrCount == wrExpected) begin
                            protoError <= 1'b1;
                        end
                    end
                end
                default: begin
                    mem.outputMemAddrReady  <= 1'b1;
                    mem.outputMemBlockReady <= 1'b0;
                    wrState                 <= W_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset)         finishedSeen <= 1'b0;
        else if (finished) finishedSeen <= 1'b1;
    end
endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int DL = 4;
    localparam int NW = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        finished = 1'b0;
    logic [31:0] writeBurstsDone;
    logic [15:0] lastWriteId;
    logic        protoError;
    logic        finishedSeen;

    mem_responder_if memIf();

    mem_responder #(.DEPTH_LOG2(DL), .CNT_BITS(32)) dut (
        .clock           (clock),
        .reset           (reset),
        .mem             (memIf),
        .finished        (finished),
        .writeBurstsDone (writeBurstsDone),
        .lastWriteId     (lastWriteId),
        .protoError      (protoError),
        .finishedSeen    (finishedSeen)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc++;

    // reference model: plain word array plus status values
    logic [511:0] modelMem [NW];
    int unsigned  modelDone;
    logic [15:0]  modelLastId;
    logic         modelProto;

    logic [511:0] rdExpQ [$];
    logic [511:0] wrBeats [$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // read-data ready: automatic patterns or manual control
    int   rdMode = 0;
    bit   rdManual = 0;
    logic manualReady = 1'b0;
    logic autoReady = 1'b1;
    assign memIf.inputMemBlockReady = rdManual ? manualReady : autoReady;

    always @(posedge clock) begin
        #1;
        case (rdMode)
            0:       autoReady = 1'b1;
            1:       autoReady = ~autoReady;
            default: autoReady = 1'($urandom_range(0, 1));
        endcase
    end

    // monitor / scoreboard for read beats
    bit           holdPending = 0;
    logic [511:0] holdData;
    int           burstBeat = 0;
    int unsigned  prevHsCyc = 0;
    bit           wantLat = 0;
    int unsigned  acceptCyc = 0;

    always @(negedge clock) begin
        if (reset) begin
            holdPending = 0;
        end else if (memIf.inputMemBlockValid) begin
            if (wantLat) begin
                chk("first-beat-latency", 512'(cyc - acceptCyc), 512'd2);
                wantLat = 0;
            end
            if (holdPending) chk("held-data", memIf.inputMemBlock, holdData);
            if (memIf.inputMemBlockReady) begin
                if (rdExpQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected-beat: got %0h want no beat", memIf.inputMemBlock);
                end else begin
                    chk("read-data", memIf.inputMemBlock, rdExpQ.pop_front());
                end
                if (rdMode == 0 && !rdManual && burstBeat > 0)
                    chk("beat-spacing", 512'(cyc - prevHsCyc), 512'd1);
                prevHsCyc = cyc;
                burstBeat++;
                holdPending = 0;
            end else begin
                holdPending = 1;
                holdData = memIf.inputMemBlock;
            end
        end else if (holdPending) begin
            chk("valid-held-until-taken", 512'd0, 512'd1);
            holdPending = 0;
        end
    end

    task automatic pushRead(input logic [63:0] addr, input logic [7:0] len);
        int base = int'(addr[6 +: DL]);
        for (int i = 0; i <= int'(len); i++) rdExpQ.push_back(modelMem[(base + i) % NW]);
    endtask

    task automatic driveReadAddr(input logic [63:0] addr, input logic [7:0] len);
        burstBeat = 0;
        @(posedge clock); #1;
        memIf.inputMemAddr = addr;
        memIf.inputMemAddrLen = len;
        memIf.inputMemAddrValid = 1'b1;
        for (int t = 0; ; t++) begin
            @(negedge clock);
            if (memIf.inputMemAddrReady) break;
            if (t > 200) begin chk("read-addr-timeout", 512'd0, 512'd1); break; end
        end
        acceptCyc = cyc;
        wantLat = 1;
        @(posedge clock); #1;
        memIf.inputMemAddrValid = 1'b0;
    endtask

    task automatic waitReadDone();
        for (int t = 0; ; t++) begin
            @(posedge clock); #2;
            if (rdExpQ.size() == 0 && memIf.inputMemAddrReady && !memIf.inputMemBlockValid) break;
            if (t > 3000) begin
                chk("read-done-timeout", 512'(rdExpQ.size()), 512'd0);
                rdExpQ.delete();
                break;
            end
        end
    endtask

    task automatic doRead(input logic [63:0] addr, input logic [7:0] len);
        pushRead(addr, len);
        driveReadAddr(addr, len);
        waitReadDone();
    endtask

    task automatic driveWriteAddr(input logic [63:0] addr, input logic [7:0] len, input logic [15:0] id);
        @(posedge clock); #1;
        memIf.outputMemAddr = addr;
        memIf.outputMemAddrLen = len;
        memIf.outputMemAddrId = id;
        memIf.outputMemAddrValid = 1'b1;
        for (int t = 0; ; t++) begin
            @(negedge clock);
            if (memIf.outputMemAddrReady) break;
            if (t > 200) begin chk("write-addr-timeout", 512'd0, 512'd1); break; end
        end
        @(posedge clock); #1;
        memIf.outputMemAddrValid = 1'b0;
    endtask

    task automatic driveBeats(input int n, input bit gaps, input bit endWithLast);
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
            memIf.outputMemBlock = wrBeats[i];
            memIf.outputMemBlockLast = endWithLast && (i == n - 1);
            memIf.outputMemBlockValid = 1'b1;
            for (int t = 0; ; t++) begin
                @(negedge clock);
                if (memIf.outputMemBlockReady) break;
                if (t > 200) begin chk("write-beat-timeout", 512'd0, 512'd1); break; end
            end
            @(posedge clock); #1;
            memIf.outputMemBlockValid = 1'b0;
            memIf.outputMemBlockLast = 1'b0;
        end
    endtask

    task automatic doWrite(input logic [63:0] addr, input logic [7:0] len, input logic [15:0] id,
                           input int n, input bit gaps);
        int base = int'(addr[6 +: DL]);
        for (int i = 0; i < n; i++) modelMem[(base + i) % NW] = wrBeats[i];
        modelDone++;
        modelLastId = id;
        if (n != int'(len) + 1) modelProto = 1'b1;
        driveWriteAddr(addr, len, id);
        driveBeats(n, gaps, 1'b1);
        chk("writeBurstsDone", 512'(writeBurstsDone), 512'(modelDone));
        chk("lastWriteId", 512'(lastWriteId), 512'(modelLastId));
        chk("protoError", 512'(protoError), 512'(modelProto));
        chk("write-idle-addr-ready", 512'(memIf.outputMemAddrReady), 512'd1);
    endtask

    // Write of one beat to wrWord lands in the same cycle the read of rdWord is fetched.
    task automatic collide(input int rdWord, input logic [7:0] rdLen, input int wrWord,
                           input logic [511:0] newData, input logic [15:0] id);
        driveWriteAddr(64'(wrWord * 64), 8'd0, id);
        rdExpQ.push_back(modelMem[rdWord % NW]);
        modelMem[wrWord % NW] = newData;
        for (int i = 1; i <= int'(rdLen); i++) rdExpQ.push_back(modelMem[(rdWord + i) % NW]);
        modelDone++;
        modelLastId = id;
        burstBeat = 0;
        chk("collide-read-ready", 512'(memIf.inputMemAddrReady), 512'd1);
        memIf.inputMemAddr = 64'(rdWord * 64);
        memIf.inputMemAddrLen = rdLen;
        memIf.inputMemAddrValid = 1'b1;
        acceptCyc = cyc;
        wantLat = 1;
        @(posedge clock); #1;
        memIf.inputMemAddrValid = 1'b0;
        chk("collide-write-ready", 512'(memIf.outputMemBlockReady), 512'd1);
        memIf.outputMemBlock = newData;
        memIf.outputMemBlockLast = 1'b1;
        memIf.outputMemBlockValid = 1'b1;
        @(posedge clock); #1;
        memIf.outputMemBlockValid = 1'b0;
        memIf.outputMemBlockLast = 1'b0;
        waitReadDone();
        chk("collide-writeBurstsDone", 512'(writeBurstsDone), 512'(modelDone));
        chk("collide-lastWriteId", 512'(lastWriteId), 512'(modelLastId));
    endtask

    task automatic checkResetState(input string tag);
        chk({tag, "-inputMemAddrReady"}, 512'(memIf.inputMemAddrReady), 512'd1);
        chk({tag, "-outputMemAddrReady"}, 512'(memIf.outputMemAddrReady), 512'd1);
        chk({tag, "-inputMemBlockValid"}, 512'(memIf.inputMemBlockValid), 512'd0);
        chk({tag, "-outputMemBlockReady"}, 512'(memIf.outputMemBlockReady), 512'd0);
        chk({tag, "-inputMemBlock"}, memIf.inputMemBlock, 512'd0);
        chk({tag, "-writeBurstsDone"}, 512'(writeBurstsDone), 512'd0);
        chk({tag, "-lastWriteId"}, 512'(lastWriteId), 512'd0);
        chk({tag, "-protoError"}, 512'(protoError), 512'd0);
        chk({tag, "-finishedSeen"}, 512'(finishedSeen), 512'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [511:0] valA, valB;
        memIf.inputMemAddr = '0;
        memIf.inputMemAddrValid = 1'b0;
        memIf.inputMemAddrLen = '0;
        memIf.outputMemAddr = '0;
        memIf.outputMemAddrValid = 1'b0;
        memIf.outputMemAddrLen = '0;
        memIf.outputMemAddrId = '0;
        memIf.outputMemBlock = '0;
        memIf.outputMemBlockValid = 1'b0;
        memIf.outputMemBlockLast = 1'b0;
        modelDone = 0;
        modelLastId = '0;
        modelProto = 1'b0;

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        checkResetState("reset");

        // write then read: 1..4 at block 1
        wrBeats.delete();
        for (int i = 0; i < 4; i++) wrBeats.push_back(512'(i + 1));
        doWrite(64'h40, 8'd3, 16'hA5A5, 4, 1'b0);
        doRead(64'h40, 8'd3);

        // fill the remaining words, wrapping from 15 to 0
        wrBeats.delete();
        for (int i = 0; i < 12; i++) wrBeats.push_back(rnd512());
        doWrite(64'(5 * 64), 8'd11, 16'h0102, 12, 1'b1);

        // read with backpressure toggling every cycle
        rdMode = 1;
        doRead(64'h100, 8'd7);
        rdMode = 0;

        // wrap: A in word 15, B in word 0
        valA = rnd512();
        valB = rnd512();
        wrBeats.delete();
        wrBeats.push_back(valA);
        wrBeats.push_back(valB);
        doWrite(64'(15 * 64), 8'd1, 16'h0F0F, 2, 1'b0);
        doRead(64'h0, 8'd0);
        doRead(64'(15 * 64), 8'd1);

        // same-cycle read/write collisions
        collide(5, 8'd0, 5, rnd512(), 16'h0C01);
        collide(4, 8'd1, 5, rnd512(), 16'h0C02);
        doRead(64'(5 * 64), 8'd0);

        // protocol error: len 3, Last on beat 2; then a legal burst
        wrBeats.delete();
        for (int i = 0; i < 2; i++) wrBeats.push_back(rnd512());
        doWrite(64'h200, 8'd3, 16'hBAD0, 2, 1'b0);
        wrBeats.delete();
        for (int i = 0; i < 2; i++) wrBeats.push_back(rnd512());
        doWrite(64'h280, 8'd1, 16'h600D, 2, 1'b0);
        doRead(64'h200, 8'd3);

        // finished flag
        chk("finishedSeen-before", 512'(finishedSeen), 512'd0);
        @(posedge clock); #1 finished = 1'b1;
        @(posedge clock); #1 finished = 1'b0;
        chk("finishedSeen-set", 512'(finishedSeen), 512'd1);
        @(posedge clock); #1;
        chk("finishedSeen-sticky", 512'(finishedSeen), 512'd1);

        // randomized traffic
        for (int it = 0; it < 40; it++) begin
            logic [63:0] addr;
            logic [7:0]  len;
            addr = {$urandom, $urandom};
            len = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                rdMode = int'($urandom_range(0, 2));
                doRead(addr, len);
                rdMode = 0;
            end else begin
                int n;
                n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, int'(len) + 2)) : int'(len) + 1;
                wrBeats.delete();
                for (int i = 0; i < n; i++) wrBeats.push_back(rnd512());
                doWrite(addr, len, 16'($urandom), n, 1'($urandom_range(0, 1)));
            end
        end

        // reset in the middle of a write burst and a read burst
        wrBeats.delete();
        for (int i = 0; i < 8; i++) wrBeats.push_back(rnd512());
        modelMem[0] = wrBeats[0];
        modelMem[1] = wrBeats[1];
        driveWriteAddr(64'h0, 8'd7, 16'h7777);
        driveBeats(2, 1'b0, 1'b0);
        rdManual = 1;
        manualReady = 1'b0;
        pushRead(64'(8 * 64), 8'd7);
        driveReadAddr(64'(8 * 64), 8'd7);
        for (int t = 0; ; t++) begin
            @(negedge clock);
            if (memIf.inputMemBlockValid) break;
            if (t > 50) begin chk("midburst-valid-timeout", 512'd0, 512'd1); break; end
        end
        @(posedge clock); #1 manualReady = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("midburst-beats-taken", 512'(rdExpQ.size()), 512'd6);
        rdExpQ.delete();
        rdManual = 0;
        modelDone = 0;
        modelLastId = '0;
        modelProto = 1'b0;
        checkResetState("midburst-reset");
        doRead(64'h0, 8'd7);
        doRead(64'(8 * 64), 8'd7);
        wrBeats.delete();
        wrBeats.push_back(rnd512());
        doWrite(64'(3 * 64), 8'd0, 16'h1234, 1, 1'b0);
        doRead(64'(3 * 64), 8'd0);

        repeat (2) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
